// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: DVI 1.0 8b/10b encoder with running-disparity DC balance, 2-cycle latency.
// Optional disparity monitor outputs are enabled with `define TMDS_DISPARITY_MON_EN.
module tmds_channel_encoder #(
    parameter logic [1:0] CTRL_RST = 2'b00
) (
    input  logic       i_pix_clk,
    input  logic       i_rst,
    input  logic       i_de,
    input  logic [7:0] i_data,
    input  logic [1:0] i_ctrl,
    output logic [9:0] o_tmds,
    output logic       o_de
`ifdef TMDS_DISPARITY_MON_EN
    ,
    output logic [4:0] o_disparity,
    output logic       o_disp_err
`endif
);

    // One spare bit lets the monitor see an excursion before truncation to 5 bits.
`ifdef TMDS_DISPARITY_MON_EN
    localparam int CW = 6;
`else
    localparam int CW = 5;
`endif
    localparam logic signed [CW-1:0] ZERO  = '0;
    localparam logic signed [CW-1:0] TWO   = CW'(2);
    localparam logic signed [CW-1:0] EIGHT = CW'(8);

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    logic [3:0] d_ones;
    logic       use_xnor;
    logic [8:0] qm;

    always_comb begin
        d_ones   = ones8(i_data);
        use_xnor = (d_ones > 4'd4) || (d_ones == 4'd4 && !i_data[0]);
        qm       = '0;
        qm[0]    = i_data[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ i_data[i]) : (qm[i-1] ^ i_data[i]);
        qm[8]    = ~use_xnor;
    end

    logic [8:0] s1_qm;
    logic       s1_de;
    logic [1:0] s1_ctrl;

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            s1_qm   <= '0;
            s1_de   <= 1'b0;
            s1_ctrl <= CTRL_RST;
        end else begin
            s1_qm   <= qm;
            s1_de   <= i_de;
            s1_ctrl <= i_ctrl;
        end
    end

    logic signed [4:0]    cnt;
    logic signed [CW-1:0] cnt_ext;
    logic signed [CW-1:0] diff;
    logic signed [CW-1:0] cnt_nxt;
    logic [3:0]           q_ones;
    logic [9:0]           tmds_nxt;

    // diff = ones - zeros of q_m[7:0] = 2*ones - 8
    always_comb begin
        q_ones   = ones8(s1_qm[7:0]);
        diff     = CW'({q_ones, 1'b0}) - EIGHT;
        cnt_ext  = CW'(cnt);
        tmds_nxt = ctrl_code(s1_ctrl);
        cnt_nxt  = ZERO;
        if (s1_de) begin
            if (cnt == 5'sd0 || diff == ZERO) begin
                tmds_nxt = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
                cnt_nxt  = cnt_ext + (s1_qm[8] ? diff : -diff);
            end else if ((cnt > 5'sd0 && diff > ZERO) || (cnt < 5'sd0 && diff < ZERO)) begin
                tmds_nxt = {1'b1, s1_qm[8], ~s1_qm[7:0]};
                cnt_nxt  = cnt_ext + (s1_qm[8] ? TWO : ZERO) - diff;
            end else begin
                tmds_nxt = {1'b0, s1_qm[8], s1_qm[7:0]};
                cnt_nxt  = cnt_ext - (s1_qm[8] ? ZERO : TWO) + diff;
            end
        end
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            o_tmds <= ctrl_code(CTRL_RST);
            o_de   <= 1'b0;
            cnt    <= '0;
        end else begin
            o_tmds <= tmds_nxt;
            o_de   <= s1_de;
            cnt    <= cnt_nxt[4:0];
        end
    end

`ifdef TMDS_DISPARITY_MON_EN
    logic disp_err;

    always_ff @(posedge i_pix_clk) begin
        if (i_rst)
            disp_err <= 1'b0;
        else if (cnt_nxt > EIGHT || cnt_nxt < -EIGHT || cnt_nxt[0])
            disp_err <= 1'b1;
    end

    assign o_disparity = cnt;
    assign o_disp_err  = disp_err;
`endif

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: directed cases then random traffic vs. a spec-level model.
module tb_tmds_channel_encoder;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       de   = 1'b0;
    logic [7:0] data = 8'h00;
    logic [1:0] ctrl = 2'b00;
    logic [9:0] tmds;
    logic       ode;
`ifdef TMDS_DISPARITY_MON_EN
    logic [4:0] disp;
    logic       derr;
`endif

    always #5 clk = ~clk;

    tmds_channel_encoder dut (
        .i_pix_clk (clk),
        .i_rst     (rst),
        .i_de      (de),
        .i_data    (data),
        .i_ctrl    (ctrl),
        .o_tmds    (tmds),
        .o_de      (ode)
`ifdef TMDS_DISPARITY_MON_EN
        ,
        .o_disparity (disp),
        .o_disp_err  (derr)
`endif
    );

    typedef struct {
        logic [9:0] tmds;
        logic       de;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   mcnt  = 0;
    int   drain = 0;
    bit   done  = 1'b0;
    logic rde   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        logic [9:0] tab [4];
        tab[0] = 10'h354;
        tab[1] = 10'h0AB;
        tab[2] = 10'h154;
        tab[3] = 10'h2AB;
        return tab[c];
    endfunction

    // Reference encoder straight from the DVI rules, disparity kept as a plain int.
    function automatic void enc(input logic [7:0] d, inout int cnt, output logic [9:0] code);
        int         n1, ones, bal;
        bit         xn;
        logic [8:0] qm;
        n1    = $countones(d);
        xn    = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        ones  = $countones(qm[7:0]);
        bal   = ones - (8 - ones);
        if (cnt == 0 || bal == 0) begin
            code = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt  = cnt + (qm[8] ? bal : -bal);
        end else if ((cnt > 0 && bal > 0) || (cnt < 0 && bal < 0)) begin
            code = {1'b1, qm[8], ~qm[7:0]};
            cnt  = cnt + (qm[8] ? 2 : 0) - bal;
        end else begin
            code = {1'b0, qm[8], qm[7:0]};
            cnt  = cnt + bal - (qm[8] ? 0 : 2);
        end
    endfunction

    task automatic drive(input logic r, input logic d, input logic [7:0] x, input logic [1:0] c);
        logic [9:0] code;
        @(posedge clk);
        #1;
        rst  = r;
        de   = d;
        data = x;
        ctrl = c;
        if (r) begin
            while (sb.size() > 0 && sb[sb.size()-1].due > cyc) sb.delete(sb.size() - 1);
            sb.push_back(exp_t'{10'h354, 1'b0, cyc + 1});
            sb.push_back(exp_t'{10'h354, 1'b0, cyc + 2});
            mcnt = 0;
        end else begin
            if (d) begin
                enc(x, mcnt, code);
            end else begin
                code = ctrl_sym(c);
                mcnt = 0;
            end
            sb.push_back(exp_t'{code, d, cyc + 2});
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_char due=%0d now=%0d", sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e_m = sb.pop_front();
            total++;
            if (tmds !== e_m.tmds || ode !== e_m.de) begin
                bad++;
                $display("FAIL char cyc=%0d got tmds=%h de=%b expected tmds=%h de=%b",
                         cyc, tmds, ode, e_m.tmds, e_m.de);
            end
        end
        if (done) begin
            drain++;
            if (sb.size() == 0 || drain > 10) begin
                if (sb.size() != 0) begin
                    total++;
                    bad++;
                    $display("FAIL drain_timeout left=%0d expected 0", sb.size());
                end
`ifdef TMDS_DISPARITY_MON_EN
                total++;
                if (derr !== 1'b0) begin
                    bad++;
                    $display("FAIL disp_err got=%b expected 0", derr);
                end
`endif
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        repeat (3) drive(1'b1, 1'b0, 8'h00, 2'b00);
        for (int c = 0; c < 4; c++) drive(1'b0, 1'b0, 8'h00, 2'(c));
        repeat (4) drive(1'b0, 1'b1, 8'h00, 2'b00);
        drive(1'b0, 1'b0, 8'h00, 2'b00);
        drive(1'b0, 1'b1, 8'hFF, 2'b00);
        drive(1'b0, 1'b0, 8'h00, 2'b00);
        drive(1'b0, 1'b1, 8'h00, 2'b11);
        drive(1'b0, 1'b0, 8'h5A, 2'b00);
        drive(1'b0, 1'b1, 8'h00, 2'b10);
        repeat (3) drive(1'b0, 1'b1, 8'h00, 2'b00);
        drive(1'b1, 1'b1, 8'h00, 2'b00);
        repeat (3) drive(1'b0, 1'b1, 8'h00, 2'b00);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) rde = ~rde;
            drive(($urandom_range(0, 149) == 0), rde, 8'($urandom), 2'($urandom));
        end
        drive(1'b0, 1'b0, 8'h00, 2'b00);
        done = 1'b1;
    end

endmodule
